// File: rtl/rsa_modexp_core.sv
// rsa_modexp_core: result = msg_block^key mod mod_n.
// Left-to-right square-and-multiply over a shared bit-serial modmul.
module rsa_modexp_core #(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [EXP_WIDTH-1:0] key,
  input  logic [WIDTH-1:0]     mod_n,
  input  logic [WIDTH-1:0]     msg_block,
  output logic                 busy,
  output logic                 complete_flag,
  output logic [WIDTH-1:0]     result,
  output logic                 error_flag
);

  localparam int CW = $clog2(WIDTH);
  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam int PW = WIDTH + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REDUCE,
    S_SQUARE,
    S_MULT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [EXP_WIDTH-1:0] r_key;
  logic [WIDTH-1:0]     r_n;
  logic [WIDTH-1:0]     r_msg;
  logic [WIDTH-1:0]     r_base;
  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]     r_result;
  logic                 r_error;
  logic [PW-1:0]        r_p;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_abit;
  logic [PW-1:0]    w_n;
  logic [PW-1:0]    w_dbl;
  logic [PW-1:0]    w_r1;
  logic [PW-1:0]    w_sum;
  logic [PW-1:0]    w_r2;
  logic [WIDTH-1:0] w_prod;
  logic             w_last;
  logic             w_kbit;
  logic             w_idx0;
  logic             w_nbad;

  assign w_last = (r_cnt == '0);
  assign w_kbit = r_key[r_idx];
  assign w_idx0 = (r_idx == '0);
  assign w_nbad = (mod_n < WIDTH'(2));

  // Operand select for the shared multiplier, by phase
  always_comb begin
    w_a = '0;
    w_b = '0;
    unique case (r_state)
      S_REDUCE: begin
        w_a = r_msg;
        w_b = WIDTH'(1);
      end
      S_SQUARE: begin
        w_a = r_acc;
        w_b = r_acc;
      end
      S_MULT: begin
        w_a = r_acc;
        w_b = r_base;
      end
      default: ;
    endcase
  end

  // One interleaved step: double, reduce, conditionally add, reduce
  always_comb begin
    w_abit = w_a[r_cnt];
    w_n    = {2'b00, r_n};
    w_dbl  = r_p << 1;
    w_r1   = (w_dbl >= w_n) ? (w_dbl - w_n) : w_dbl;
    w_sum  = w_r1 + (w_abit ? {2'b00, w_b} : '0);
    w_r2   = (w_sum >= w_n) ? (w_sum - w_n) : w_sum;
    w_prod = w_r2[WIDTH-1:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state: each multiply phase lasts until its last bit
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = w_nbad ? S_DONE : S_REDUCE;
      end
      S_REDUCE: begin
        if (w_last) w_next = S_SQUARE;
      end
      S_SQUARE: begin
        if (w_last) begin
          if (w_kbit)      w_next = S_MULT;
          else if (w_idx0) w_next = S_DONE;
          else             w_next = S_SQUARE;
        end
      end
      S_MULT: begin
        if (w_last) w_next = w_idx0 ? S_DONE : S_SQUARE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: operand latch, multiplier iteration, phase write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key    <= '0;
      r_n      <= '0;
      r_msg    <= '0;
      r_base   <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_error  <= 1'b0;
      r_p      <= '0;
      r_cnt    <= '0;
      r_idx    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_key    <= key;
            r_n      <= mod_n;
            r_msg    <= msg_block;
            r_result <= '0;
            r_error  <= w_nbad;
            r_p      <= '0;
            r_cnt    <= CW'(WIDTH - 1);
            r_idx    <= IW'(EXP_WIDTH - 1);
          end
        end
        S_REDUCE, S_SQUARE, S_MULT: begin
          if (!w_last) begin
            r_p   <= w_r2;
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_p   <= '0;
            r_cnt <= CW'(WIDTH - 1);
            if (r_state == S_REDUCE) begin
              r_base <= w_prod;
              r_acc  <= WIDTH'(1);
            end else begin
              r_acc <= w_prod;
            end
            if (r_state == S_SQUARE && !w_kbit) begin
              if (w_idx0) r_result <= w_prod;
              else        r_idx    <= r_idx - 1'b1;
            end
            if (r_state == S_MULT) begin
              if (w_idx0) r_result <= w_prod;
              else        r_idx    <= r_idx - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == S_REDUCE) ||
                (r_state == S_SQUARE) ||
                (r_state == S_MULT);
  assign complete_flag = (r_state == S_DONE);
  assign result        = r_result;
  assign error_flag    = r_error;

endmodule
